// File: rtl/context_sequencer.sv
// context_sequencer: owns the context counter (CCNT) and resolves halt/jump/predicated branches.
// Optional watchdog abort is compiled in when CONTEXT_SEQ_WDOG_EN is defined.
module context_sequencer #(
    parameter int CCNT_WIDTH    = 8,
    parameter int CONTEXT_DEPTH = 256,
    parameter int WDOG_CYCLES   = 1024
) (
    input  logic                  CLK_I,
    input  logic                  RST_N_I,
    input  logic                  EN_I,
    input  logic                  START_I,
    input  logic [CCNT_WIDTH-1:0] START_ADDR_I,
    input  logic                  PRED_I,
    input  logic [CCNT_WIDTH+3:0] CTRL_I,
    output logic [CCNT_WIDTH-1:0] CCNT_O,
    output logic                  RUN_O,
    output logic                  DONE_O,
    output logic                  ERR_O
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state;

    if (CONTEXT_DEPTH > (2 ** CCNT_WIDTH) || CONTEXT_DEPTH < 1 || WDOG_CYCLES < 2) begin : g_bad_params
        $error("context_sequencer: illegal CONTEXT_DEPTH/WDOG_CYCLES for CCNT_WIDTH");
    end

    logic                  halt;
    logic                  jump;
    logic                  cond;
    logic                  inv;
    logic                  taken;
    logic [CCNT_WIDTH-1:0] target;
    logic [CCNT_WIDTH-1:0] start_addr_ok;
    logic [CCNT_WIDTH-1:0] target_ok;
    logic [CCNT_WIDTH-1:0] ccnt_inc;

    assign halt   = CTRL_I[CCNT_WIDTH+3];
    assign jump   = CTRL_I[CCNT_WIDTH+2];
    assign cond   = CTRL_I[CCNT_WIDTH+1];
    assign inv    = CTRL_I[CCNT_WIDTH];
    assign target = CTRL_I[CCNT_WIDTH-1:0];
    assign taken  = jump & (~cond | (PRED_I ^ inv));

    // Out-of-range addresses fall back to context 0 rather than aliasing into the memory.
    assign start_addr_ok = (32'(START_ADDR_I) < 32'(CONTEXT_DEPTH)) ? START_ADDR_I : '0;
    assign target_ok     = (32'(target) < 32'(CONTEXT_DEPTH)) ? target : '0;
    assign ccnt_inc      = (32'(CCNT_O) == 32'(CONTEXT_DEPTH - 1)) ? '0 : CCNT_O + 1'b1;

`ifdef CONTEXT_SEQ_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

    logic [WDOG_W-1:0] wdog_cnt;
    logic              err_q;
    logic              wdog_expire;

    assign wdog_expire = (wdog_cnt == WDOG_LAST);
    assign ERR_O       = err_q;
`else
    assign ERR_O = 1'b0;
`endif

    // Handshake: START_I is a request taken only in IDLE with EN_I high; there is no ready,
    // acceptance shows as RUN_O=1 after the sampling edge. EN_I low freezes every register.
    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            state  <= ST_IDLE;
            CCNT_O <= '0;
            RUN_O  <= 1'b0;
            DONE_O <= 1'b0;
`ifdef CONTEXT_SEQ_WDOG_EN
            wdog_cnt <= '0;
            err_q    <= 1'b0;
`endif
        end else if (EN_I) begin
            unique case (state)
                ST_IDLE: begin
                    if (START_I) begin
                        state  <= ST_RUN;
                        CCNT_O <= start_addr_ok;
                        RUN_O  <= 1'b1;
`ifdef CONTEXT_SEQ_WDOG_EN
                        wdog_cnt <= '0;
                        err_q    <= 1'b0;
`endif
                    end
                end
                ST_RUN: begin
`ifdef CONTEXT_SEQ_WDOG_EN
                    wdog_cnt <= wdog_cnt + 1'b1;
`endif
                    if (halt) begin
                        state  <= ST_DONE;
                        RUN_O  <= 1'b0;
                        DONE_O <= 1'b1;
`ifdef CONTEXT_SEQ_WDOG_EN
                    end else if (wdog_expire) begin
                        state  <= ST_DONE;
                        RUN_O  <= 1'b0;
                        DONE_O <= 1'b1;
                        err_q  <= 1'b1;
`endif
                    end else if (taken) begin
                        CCNT_O <= target_ok;
                    end else begin
                        CCNT_O <= ccnt_inc;
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    DONE_O <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    RUN_O  <= 1'b0;
                    DONE_O <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_context_sequencer.sv
// Directed bench for context_sequencer with a small behavioural context memory (CONTEXT_DEPTH=16).
// Watchdog cases are compiled only when CONTEXT_SEQ_WDOG_EN is defined.
module tb_context_sequencer;
    localparam int CW = 8;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic          start;
    logic [CW-1:0] start_addr;
    logic          pred;
    logic [CW+3:0] ctrl;
    logic [CW-1:0] ccnt;
    logic          run;
    logic          done;
    logic          err;

    logic [CW+3:0] ctx_mem [0:255];

    int checks_total;
    int checks_passed;

    context_sequencer #(
        .CCNT_WIDTH   (CW),
        .CONTEXT_DEPTH(16),
        .WDOG_CYCLES  (8)
    ) dut (
        .CLK_I       (clk),
        .RST_N_I     (rst_n),
        .EN_I        (en),
        .START_I     (start),
        .START_ADDR_I(start_addr),
        .PRED_I      (pred),
        .CTRL_I      (ctrl),
        .CCNT_O      (ccnt),
        .RUN_O       (run),
        .DONE_O      (done),
        .ERR_O       (err)
    );

    // Combinational context memory read, addressed by the current CCNT.
    assign ctrl = ctx_mem[ccnt];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got === exp) checks_passed++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CW+3:0] mk(input logic h, input logic j, input logic c,
                                         input logic i, input logic [CW-1:0] t);
        return {h, j, c, i, t};
    endfunction

    task automatic clear_mem();
        for (int k = 0; k < 256; k++) ctx_mem[k] = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic start_run(input logic [CW-1:0] addr);
        start      = 1'b1;
        start_addr = addr;
        tick();
        start = 1'b0;
    endtask

    // Branch table: inv, cond, pred -> expected next CCNT from context 2 (TARGET=9).
    logic       br_inv  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       br_cond [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       br_pred [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [7:0] br_exp  [6] = '{8'd9, 8'd3, 8'd3, 8'd9, 8'd9, 8'd9};

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        clear_mem();
        rst_n      = 1'b0;
        en         = 1'b0;
        start      = 1'b0;
        start_addr = '0;
        pred       = 1'b0;
        tick();
        check_val("rst_ccnt", 32'(ccnt), 0);
        check_val("rst_run", 32'(run), 0);
        check_val("rst_done", 32'(done), 0);
        check_val("rst_err", 32'(err), 0);
        rst_n = 1'b1;
        en    = 1'b1;
        tick();

        // Linear run 3..6, halt at 6.
        ctx_mem[6] = mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        start_run(8'd3);
        check_val("lin_start_ccnt", 32'(ccnt), 3);
        check_val("lin_start_run", 32'(run), 1);
        for (int k = 4; k <= 6; k++) begin
            tick();
            check_val("lin_ccnt", 32'(ccnt), 32'(k));
            check_val("lin_done_low", 32'(done), 0);
        end
        tick();
        check_val("lin_done", 32'(done), 1);
        check_val("lin_run_off", 32'(run), 0);
        check_val("lin_hold", 32'(ccnt), 6);
        tick();
        check_val("lin_done_1cyc", 32'(done), 0);
        check_val("lin_idle_run", 32'(run), 0);
        check_val("lin_err", 32'(err), 0);

        // Halt at start address, START ignored in RUN/DONE, accepted in first IDLE cycle.
        clear_mem();
        ctx_mem[5] = mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        start_run(8'd5);
        check_val("b2b_ccnt", 32'(ccnt), 5);
        start      = 1'b1;
        start_addr = 8'd7;
        tick();
        check_val("b2b_done", 32'(done), 1);
        check_val("b2b_ccnt_hold", 32'(ccnt), 5);
        tick();
        check_val("b2b_idle_done", 32'(done), 0);
        check_val("b2b_idle_run", 32'(run), 0);
        check_val("b2b_idle_ccnt", 32'(ccnt), 5);
        tick();
        start = 1'b0;
        check_val("b2b_restart_run", 32'(run), 1);
        check_val("b2b_restart_ccnt", 32'(ccnt), 7);
        do_reset();

        // Conditional / unconditional branch at context 2.
        for (int k = 0; k < 6; k++) begin
            clear_mem();
            ctx_mem[2] = mk(1'b0, 1'b1, br_cond[k], br_inv[k], 8'd9);
            pred = br_pred[k];
            start_run(8'd2);
            tick();
            check_val($sformatf("branch_%0d", k), 32'(ccnt), 32'(br_exp[k]));
            do_reset();
        end
        pred = 1'b0;

        // HALT has priority over JUMP.
        clear_mem();
        ctx_mem[2] = mk(1'b1, 1'b1, 1'b0, 1'b0, 8'd9);
        start_run(8'd2);
        tick();
        check_val("halt_prio_done", 32'(done), 1);
        check_val("halt_prio_ccnt", 32'(ccnt), 2);
        do_reset();

        // Wrap and bounds.
        clear_mem();
        start_run(8'd15);
        tick();
        check_val("wrap_15", 32'(ccnt), 0);
        do_reset();
        ctx_mem[2] = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'd20);
        start_run(8'd2);
        tick();
        check_val("target_oob", 32'(ccnt), 0);
        do_reset();
        clear_mem();
        start_run(8'd17);
        check_val("start_oob", 32'(ccnt), 0);
        check_val("start_oob_run", 32'(run), 1);
        do_reset();

        // Enable freeze mid-run, START ignored in RUN.
        start_run(8'd4);
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_val("en_freeze", 32'(ccnt), 4);
        end
        en = 1'b1;
        tick();
        check_val("en_resume", 32'(ccnt), 5);
        start      = 1'b1;
        start_addr = 8'd10;
        tick();
        start = 1'b0;
        check_val("start_in_run", 32'(ccnt), 6);
        do_reset();

        // START with EN low in IDLE.
        en         = 1'b0;
        start      = 1'b1;
        start_addr = 8'd3;
        tick();
        check_val("start_en0_run", 32'(run), 0);
        en    = 1'b1;
        start = 1'b0;
        tick();
        check_val("start_en0_still_idle", 32'(run), 0);
        check_val("start_en0_ccnt", 32'(ccnt), 0);

        // DONE frozen by EN low stays asserted.
        ctx_mem[1] = mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        start_run(8'd1);
        tick();
        check_val("done_freeze_pre", 32'(done), 1);
        en = 1'b0;
        tick();
        tick();
        check_val("done_freeze", 32'(done), 1);
        en = 1'b1;
        tick();
        check_val("done_release", 32'(done), 0);

        // Asynchronous reset mid-run at CCNT 5.
        clear_mem();
        start_run(8'd3);
        tick();
        tick();
        check_val("midrst_pre", 32'(ccnt), 5);
        rst_n = 1'b0;
        #2;
        check_val("midrst_ccnt", 32'(ccnt), 0);
        check_val("midrst_run", 32'(run), 0);
        check_val("midrst_done", 32'(done), 0);
        rst_n = 1'b1;
        tick();

`ifdef CONTEXT_SEQ_WDOG_EN
        // Self-loop at 0 without halt: abort after 8 RUN cycles.
        clear_mem();
        ctx_mem[0] = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        start_run(8'd0);
        for (int k = 0; k < 7; k++) tick();
        check_val("wdog_still_run", 32'(run), 1);
        tick();
        check_val("wdog_done", 32'(done), 1);
        check_val("wdog_err", 32'(err), 1);
        tick();
        check_val("wdog_err_sticky", 32'(err), 1);
        start_run(8'd0);
        check_val("wdog_err_clear", 32'(err), 0);
        do_reset();

        // HALT in the expiry cycle wins.
        start_run(8'd0);
        for (int k = 0; k < 7; k++) tick();
        ctx_mem[0] = mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        tick();
        check_val("wdog_halt_done", 32'(done), 1);
        check_val("wdog_halt_err", 32'(err), 0);
        do_reset();
`endif

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule

// File: doc/context_sequencer.md
# context_sequencer

Context sequencer for the CGRA control path: it owns the context counter (CCNT) that addresses the context memories and consumes the predicate produced by the predication box to resolve conditional branches. Each enabled cycle it reads the control word of the current context, evaluates halt/jump/condition against the predicate and advances CCNT. It runs from a start pulse until a halt context, then signals completion.

## Interface
Parameters:
- CCNT_WIDTH, 8: context counter width.
- CONTEXT_DEPTH, 256: number of valid contexts, ≤ 2^CCNT_WIDTH.
- WDOG_CYCLES, 1024: watchdog limit, used only with CONTEXT_SEQ_WDOG_EN.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- CLK_I  in  1  clock.
- RST_N_I  in  1  asynchronous active-low reset.
- EN_I  in  1  global enable. When 0, all state holds and START_I is ignored.
- START_I  in  1  start request; sampled in IDLE only.
- START_ADDR_I  in  CCNT_WIDTH  first context address.
- PRED_I  in  1  predicate (combinational predication-box output) for the context at CCNT_O.
- CTRL_I  in  CCNT_WIDTH+4  control word of the context at CCNT_O: [CCNT_WIDTH+3]=HALT, [+2]=JUMP, [+1]=COND, [+0]=INV, [CCNT_WIDTH-1:0]=TARGET.
- CCNT_O  out  CCNT_WIDTH  current context address (registered).
- RUN_O  out  1  high in RUN.
- DONE_O  out  1  single-cycle completion pulse.
- ERR_O  out  1  watchdog abort flag; tied 0 without the macro.

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: CCNT_O=0, RUN_O=0, DONE_O=0, ERR_O=0.
- IDLE:
  - START_I=1 & EN_I=1 → CCNT<=START_ADDR_I, go to RUN.
  - START_ADDR_I ≥ CONTEXT_DEPTH loads 0.
- RUN (each EN_I=1 cycle):
  - HALT=1 → go to DONE; CCNT holds. HALT has priority over JUMP.
  - Otherwise taken = JUMP & (~COND | (PRED_I ^ INV)).
  - Taken → CCNT<=TARGET. A TARGET ≥ CONTEXT_DEPTH loads 0.
  - Not taken → CCNT<=CCNT+1. CCNT = CONTEXT_DEPTH-1 wraps to 0.
  - START_I is ignored in RUN.
- DONE:
  - DONE_O=1 for exactly one cycle, then go to IDLE. CCNT holds the halt address.
  - START_I in DONE is ignored.
- EN_I=0 in any state: no transition, outputs frozen, and DONE_O stays asserted if frozen in DONE.
- Reset asserted mid-run: immediate return to reset values, independent of clock.
- The branch is a single-level decision: no call stack, no loop counter.

## Timing
- START_I sampled at edge N → RUN_O=1 and CCNT_O=START_ADDR_I after edge N.
- CTRL_I and PRED_I must correspond to CCNT_O in the same cycle, so the context memory read is combinational. The next CCNT_O is visible after the following edge, giving one context per cycle.
- Halt context at CCNT_O in cycle K → DONE_O=1 and RUN_O=0 in cycle K+1 → IDLE in K+2.
- Minimum START-to-DONE: 2 edges (halt at the start address).
- Back-to-back: a new START_I is accepted in the first IDLE cycle after DONE.

## Configuration
- Macro: CONTEXT_SEQ_WDOG_EN.
- Defined:
  - A cycle counter of width clog2(WDOG_CYCLES) clears on the accepted START and increments on each enabled RUN cycle.
  - When the counter reaches WDOG_CYCLES-1 in RUN without HALT → go to DONE with ERR_O<=1.
  - ERR_O is sticky until the next accepted START or reset.
  - Simultaneous HALT and expiry: HALT wins, ERR_O stays 0.
- Undefined: no counter is generated, ERR_O is constant 0, and a non-halting program runs forever.

## Test plan
- Reset then idle: RST_N_I low mid-RUN at CCNT=5 → CCNT_O=0, RUN_O=0, DONE_O=0 immediately, with no clock edge needed.
- Linear run, CONTEXT_DEPTH=16, START_ADDR=3, HALT at context 6 → CCNT_O sequence 3,4,5,6; DONE_O pulses once in the cycle after 6; back in IDLE one cycle later.
- Conditional branch at context 2 (JUMP=1, COND=1, INV=0, TARGET=9): PRED_I=1 → next CCNT=9; PRED_I=0 → next CCNT=3; INV=1 inverts both outcomes. Unconditional (COND=0) → 9 regardless of PRED_I.
- Wrap and bounds, CONTEXT_DEPTH=16:
  - Non-branch at context 15 → CCNT=0.
  - TARGET=20 taken → CCNT=0.
  - START_ADDR=17 → CCNT=0.
- Enable and start interplay:
  - EN_I=0 for 3 cycles mid-RUN at CCNT=4 → CCNT_O stays 4, resumes at 5.
  - START_I during RUN → no effect.
  - START_I with EN_I=0 in IDLE → stays IDLE.
- With CONTEXT_SEQ_WDOG_EN, WDOG_CYCLES=8, loop context 0→0 without halt:
  - DONE_O and ERR_O=1 after 8 RUN cycles; ERR_O clears on the next START.
  - HALT exactly in the expiry cycle → ERR_O=0.
